mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Requester 1 is the multicycle CPU core: IF fetch and MA/SW/LW accesses, already muxed by IorD.
- Requester 2 is an auxiliary master: program loader / debug port.
- Single-cycle request/grant handshake, registered read-valid, CPU-priority arbitration with a starvation bound for the aux port. Sits between the core and the memory block.

Parameters:
WIDTH, 32, data width
ADDR_W, 32, address width
MAX_BURST, 4, max consecutive CPU grants while aux_req is pending (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write enable (1=SW, 0=fetch/LW)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  WIDTH  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  WIDTH  CPU read data
cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes core FSM
aux_req  in  1  aux access request
aux_we  in  1  aux write enable
aux_addr  in  ADDR_W  aux address
aux_wdata  in  WIDTH  aux write data
aux_gnt  out  1  aux access accepted this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  WIDTH  aux read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid 1 cycle after read strobe

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt=1.
  - req&gnt in cycle N means the access is issued on the mem_* pins in cycle N.
  - Reads: rvalid=1 and rdata=mem_rdata in cycle N+1 for the granted requester only.
  - Writes: no rvalid.
- Grants are combinational from the current state and requests. At most one gnt per cycle.
- mem_en = cpu_gnt|aux_gnt. mem_we/addr/wdata are muxed from the granted requester; mem_we=0 and mem_addr/wdata=0 when idle.
- Per cycle, the two requests are always issued one at a time by the mux, so they can never collide.
- State machine: IDLE / CPU_OWN / AUX_OWN (owner of the last granted access), plus burst counter cnt[3:0].
  - No request: no grant; state -> IDLE; cnt -> 0.
  - Only cpu_req: grant CPU; -> CPU_OWN; cnt -> 0.
  - Only aux_req: grant aux; -> AUX_OWN; cnt -> 0.
  - Both, cnt < MAX_BURST: grant CPU; -> CPU_OWN; cnt+1.
  - Both, cnt == MAX_BURST: grant aux; -> AUX_OWN; cnt -> 0.
  - Aux never gets two consecutive grants while cpu_req is high. From AUX_OWN with both requesting, CPU wins.
- Read tracking: rd_pend_cpu / rd_pend_aux registers, set on a granted read and cleared the next cycle. These drive cpu_rvalid / aux_rvalid.
- Reset:
  - While rst=1: all gnt=0, mem_en=0, state=IDLE, cnt=0, rvalid=0.
  - A read granted in the cycle before reset asserts produces no rvalid.
- Reset value of every registered output is 0. cpu_rdata/aux_rdata pass mem_rdata through and are don't-care when rvalid=0.
- cpu_stall is asserted only when cpu_req=1 and cpu_gnt=0.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds output port cpu_stall_cnt [31:0], a saturating count of cycles with cpu_stall=1 (holds at 32'hFFFFFFFF); cleared by rst.
- Undefined: port and counter absent; arbitration behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles while cpu_req=1 and aux_req=1 -> cpu_gnt=0, aux_gnt=0, mem_en=0; after release, the first grant goes to the CPU.
- CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=32'h40; memory returns 32'hDEADBEEF -> cpu_gnt=1 in cycle N; cpu_rvalid=1 with cpu_rdata=32'hDEADBEEF in N+1; aux_rvalid=0.
- Contention, MAX_BURST=4: both requests held high -> grant sequence CPU,CPU,CPU,CPU,AUX,CPU,CPU,CPU,CPU,AUX; cpu_stall=1 exactly on the AUX cycles.
- Aux write alone: aux_req=1, aux_we=1, aux_addr=32'h10, aux_wdata=32'h12345678 -> mem_en=1, mem_we=1 with that addr/data for 1 cycle; no rvalid.
- Reset mid-read: CPU read granted at cycle N with rst=1 at N+1 -> cpu_rvalid stays 0.
- ARB_STATS_EN: 10 cycles of contention, MAX_BURST=4 -> cpu_stall_cnt=2; rst -> 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified memory between the CPU core and an aux master.
// Optional ARB_STATS_EN adds a saturating cpu_stall_cnt output.
module mem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [WIDTH-1:0]  aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [WIDTH-1:0]  aux_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       cpu_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CPU_OWN, AUX_OWN} state_e;

    localparam logic [3:0] MAX_C = 4'(MAX_BURST);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_pend_cpu_q, rd_pend_cpu_d;
    logic       rd_pend_aux_q, rd_pend_aux_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            rd_pend_cpu_q <= 1'b0;
            rd_pend_aux_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_pend_cpu_q <= rd_pend_cpu_d;
            rd_pend_aux_q <= rd_pend_aux_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!rst) begin
            if (cpu_req && aux_req) begin
                // Aux only wins once the CPU has used its full burst and did not just lose to aux.
                if (cnt_q >= MAX_C && state_q != AUX_OWN) begin
                    aux_gnt = 1'b1;
                    state_d = AUX_OWN;
                end else begin
                    cpu_gnt = 1'b1;
                    state_d = CPU_OWN;
                    cnt_d   = cnt_q + 4'd1;
                end
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
                state_d = CPU_OWN;
            end else if (aux_req) begin
                aux_gnt = 1'b1;
                state_d = AUX_OWN;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | aux_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (aux_gnt) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
        end
        rd_pend_cpu_d = cpu_gnt & ~cpu_we;
        rd_pend_aux_d = aux_gnt & ~aux_we;
    end

    // A read pending across the edge into reset must not surface during the reset cycle.
    assign cpu_rvalid = rd_pend_cpu_q & ~rst;
    assign aux_rvalid = rd_pend_aux_q & ~rst;
    assign cpu_rdata  = mem_rdata;
    assign aux_rdata  = mem_rdata;
    assign cpu_stall  = cpu_req & ~cpu_gnt;

`ifdef ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule
